// File: rtl/axis_blender_ml.sv
// Multi-layer AXI-stream overlay compositor: blends up to C_LAYER_NUM alpha layers onto a base
// video stream through a fixed-latency pipeline with frame-latched enables and layer SOF resync.
module axis_blender_ml #(
    parameter int C_CHN_WIDTH      = 8,
    parameter int C_S0_CHN_NUM     = 3,
    parameter int C_S1_CHN_NUM     = 3,
    parameter int C_ALPHA_WIDTH    = 8,
    parameter int C_LAYER_NUM      = 2,
    parameter int C_IN_NEED_WIDTH  = 3,
    parameter int C_OUT_NEED_WIDTH = 1
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic                                       s0_axis_tvalid,
    output logic                                       s0_axis_tready,
    input  logic [C_S0_CHN_NUM*C_CHN_WIDTH-1:0]        s0_axis_tdata,
    input  logic [C_IN_NEED_WIDTH:0]                   s0_axis_tuser,
    input  logic                                       s0_axis_tlast,
    input  logic [C_LAYER_NUM-1:0]                     sl_axis_tvalid,
    output logic [C_LAYER_NUM-1:0]                     sl_axis_tready,
    input  logic [C_LAYER_NUM*(C_S1_CHN_NUM*C_CHN_WIDTH+C_ALPHA_WIDTH)-1:0] sl_axis_tdata,
    input  logic [C_LAYER_NUM-1:0]                     sl_axis_tuser,
    input  logic [C_LAYER_NUM-1:0]                     layer_enable,
    output logic [C_LAYER_NUM-1:0]                     sync_err,
    output logic                                       m_axis_tvalid,
    input  logic                                       m_axis_tready,
    output logic [C_S0_CHN_NUM*C_CHN_WIDTH-1:0]        m_axis_tdata,
    output logic [C_OUT_NEED_WIDTH:0]                  m_axis_tuser,
    output logic                                       m_axis_tlast
);

    localparam int L   = C_LAYER_NUM;
    localparam int CW  = C_CHN_WIDTH;
    localparam int MW  = C_S0_CHN_NUM * C_CHN_WIDTH;
    localparam int LW  = C_S1_CHN_NUM * C_CHN_WIDTH + C_ALPHA_WIDTH;
    localparam int AWI = (C_ALPHA_WIDTH > 0) ? C_ALPHA_WIDTH : 1;
    localparam int OU  = C_OUT_NEED_WIDTH + 1;

    // Per-channel (fg*a' + bg*(2^AW - a')) >> AW, where all-ones alpha means fully opaque.
    function automatic logic [MW-1:0] mix_px(input logic [MW-1:0] fg,
                                             input logic [MW-1:0] bg,
                                             input logic [AWI-1:0] alpha);
        logic [AWI:0]      a;
        logic [AWI:0]      ainv;
        logic [CW+AWI:0]   acc;
        logic [MW-1:0]     res;
        a    = (&alpha) ? {1'b1, {AWI{1'b0}}} : {1'b0, alpha};
        ainv = {1'b1, {AWI{1'b0}}} - a;
        res  = '0;
        for (int c = 0; c < C_S0_CHN_NUM; c++) begin
            acc = ({{(AWI+1){1'b0}}, fg[c*CW +: CW]} * {{CW{1'b0}}, a})
                + ({{(AWI+1){1'b0}}, bg[c*CW +: CW]} * {{CW{1'b0}}, ainv});
            res[c*CW +: CW] = acc[AWI +: CW];
        end
        return res;
    endfunction

    // Pipeline state: stage 0 is the join register, stage L drives the master port.
    logic [L:0]     vld_r;
    logic [L:0]     lst_r;
    logic [MW-1:0]  pix_r  [0:L];
    logic [OU-1:0]  usr_r  [0:L];
    logic [L-1:0]   need_r [0:L-1];
    logic [LW-1:0]  ldat_r [0:L-1][0:L-1];
    logic [MW-1:0]  blend_s [0:L-1];

    logic [L-1:0]   en_lat_r;
    logic [L-1:0]   expect_sof_r;
    logic [L-1:0]   sync_err_r;

    logic           adv_s;
    logic           fire_s;
    logic [L-1:0]   en_eff_s;
    logic [L-1:0]   need_s;
    logic [L-1:0]   drop_s;
    logic [L-1:0]   ok_s;
    logic [L-1:0]   expect_nxt_s;
    logic [OU-1:0]  usr_join_s;

    // Join decision: which layers this base pixel needs and whether every needed beat is ready.
    always_comb begin
        adv_s = ~vld_r[L] | m_axis_tready;
        if (s0_axis_tuser[0]) begin
            en_eff_s = layer_enable;
        end else begin
            en_eff_s = en_lat_r;
        end
        need_s = s0_axis_tuser[L:1] & en_eff_s;
        drop_s = expect_sof_r & sl_axis_tvalid & ~sl_axis_tuser;
        ok_s   = ~need_s | (sl_axis_tvalid & ~drop_s);
        fire_s = adv_s & s0_axis_tvalid & (&ok_s) & ~reset;
        // A consumed layer SOF wins over a same-cycle base SOF.
        expect_nxt_s = (expect_sof_r | {L{fire_s & s0_axis_tuser[0]}})
                     & ~(need_s & sl_axis_tuser & {L{fire_s}});
    end

    assign s0_axis_tready = fire_s;
    assign sl_axis_tready = (need_s & {L{fire_s}}) | (drop_s & {L{~reset}});

    generate
        if (C_OUT_NEED_WIDTH > 0) begin : g_usr_pass
            assign usr_join_s = {s0_axis_tuser[C_IN_NEED_WIDTH:L+1], s0_axis_tuser[0]};
        end else begin : g_usr_sof
            assign usr_join_s = s0_axis_tuser[0];
        end
    endgenerate

    generate
        for (genvar k = 0; k < L; k++) begin : g_blend
            logic [MW-1:0] fg_s;
            if (C_S1_CHN_NUM == 1) begin : g_grey
                assign fg_s = {C_S0_CHN_NUM{ldat_r[k][k][CW-1:0]}};
            end else begin : g_colour
                assign fg_s = ldat_r[k][k][MW-1:0];
            end
            if (C_ALPHA_WIDTH == 0) begin : g_opaque
                assign blend_s[k] = need_r[k][k] ? fg_s : pix_r[k];
            end else begin : g_alpha
                assign blend_s[k] = need_r[k][k] ? mix_px(fg_s, pix_r[k], ldat_r[k][k][LW-1 -: AWI])
                                                 : pix_r[k];
            end
        end
    endgenerate

    // Blend pipeline: every stage shifts together whenever the output can advance.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_r <= '0;
            lst_r <= '0;
            for (int s = 0; s <= L; s++) begin
                pix_r[s] <= '0;
                usr_r[s] <= '0;
            end
            for (int s = 0; s < L; s++) begin
                need_r[s] <= '0;
                for (int k = 0; k < L; k++) begin
                    ldat_r[s][k] <= '0;
                end
            end
        end else if (adv_s) begin
            vld_r     <= {vld_r[L-1:0], fire_s};
            lst_r     <= {lst_r[L-1:0], s0_axis_tlast};
            pix_r[0]  <= s0_axis_tdata;
            usr_r[0]  <= usr_join_s;
            need_r[0] <= need_s;
            for (int k = 0; k < L; k++) begin
                ldat_r[0][k] <= sl_axis_tdata[k*LW +: LW];
            end
            for (int s = 1; s <= L; s++) begin
                pix_r[s] <= blend_s[s-1];
                usr_r[s] <= usr_r[s-1];
            end
            for (int s = 1; s < L; s++) begin
                need_r[s] <= need_r[s-1];
                for (int k = 0; k < L; k++) begin
                    ldat_r[s][k] <= ldat_r[s-1][k];
                end
            end
        end
    end

    // Frame-level control: enable latch, SOF expectation and sticky misalignment flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            en_lat_r     <= '0;
            expect_sof_r <= '1;
            sync_err_r   <= '0;
        end else begin
            if (fire_s && s0_axis_tuser[0]) begin
                en_lat_r <= layer_enable;
            end
            expect_sof_r <= expect_nxt_s;
            sync_err_r   <= sync_err_r | drop_s;
        end
    end

    assign m_axis_tvalid = vld_r[L];
    assign m_axis_tdata  = pix_r[L];
    assign m_axis_tuser  = usr_r[L];
    assign m_axis_tlast  = lst_r[L];
    assign sync_err      = sync_err_r;

endmodule

// File: tb/tb_axis_blender_ml.sv
// Randomised scoreboard bench for axis_blender_ml: a frame-level model predicts each output pixel
// while independent driver and monitor processes exercise the handshakes.
`timescale 1ns/1ps
module tb_axis_blender_ml;

    localparam int L  = 2;
    localparam int MW = 24;
    localparam int LW = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic            s0_axis_tvalid, s0_axis_tready, s0_axis_tlast;
    logic [MW-1:0]   s0_axis_tdata;
    logic [3:0]      s0_axis_tuser;
    logic [L-1:0]    sl_axis_tvalid, sl_axis_tready, sl_axis_tuser, layer_enable, sync_err;
    logic [L*LW-1:0] sl_axis_tdata;
    logic            m_axis_tvalid, m_axis_tready, m_axis_tlast;
    logic [MW-1:0]   m_axis_tdata;
    logic [1:0]      m_axis_tuser;

    always #5 clk = ~clk;

    axis_blender_ml dut (
        .clk(clk), .reset(reset),
        .s0_axis_tvalid(s0_axis_tvalid), .s0_axis_tready(s0_axis_tready),
        .s0_axis_tdata(s0_axis_tdata), .s0_axis_tuser(s0_axis_tuser), .s0_axis_tlast(s0_axis_tlast),
        .sl_axis_tvalid(sl_axis_tvalid), .sl_axis_tready(sl_axis_tready),
        .sl_axis_tdata(sl_axis_tdata), .sl_axis_tuser(sl_axis_tuser),
        .layer_enable(layer_enable), .sync_err(sync_err),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast)
    );

    typedef struct packed {logic [23:0] d; logic [3:0] u; logic l; logic [1:0] en;} base_t;
    typedef struct packed {logic [31:0] d; logic sof;} lay_t;
    typedef struct packed {logic [23:0] d; logic [1:0] u; logic l;} exp_t;

    base_t bq[$];
    lay_t  lq[L][$];
    exp_t  sb[$];

    int checks = 0, errors = 0;
    int cyc = 0, out_cnt = 0, hits = 0;
    int first_acc = -1, first_out = -1;
    int hs_cnt [L];
    logic [23:0] watch = 24'h0;
    bit halt = 1'b1, det = 1'b1;

    // frame description used by build_frame
    int rx [L], ry [L], rw [L], rh [L], lval [L], lalp [L];
    logic [1:0] en_sof, en_mid;
    int mid_row;
    bit rnd_cover, base_zero;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    function automatic logic [23:0] mix(input logic [23:0] bg, input logic [23:0] fg, input logic [7:0] a);
        int ap;
        logic [23:0] r;
        ap = (a == 8'hFF) ? 256 : int'(a);
        for (int c = 0; c < 3; c++) begin
            r[c*8 +: 8] = 8'((int'(fg[c*8 +: 8]) * ap + int'(bg[c*8 +: 8]) * (256 - ap)) / 256);
        end
        return r;
    endfunction

    task automatic set_layer(input int k, x, y, w, h, v, a);
        rx[k] = x; ry[k] = y; rw[k] = w; rh[k] = h; lval[k] = v; lalp[k] = a;
    endtask

    // Generate one frame of stimulus and, from the compositing rules, its expected output.
    task automatic build_frame(input int w, input int h);
        bit first [L];
        logic [23:0] bg, px, v;
        logic [7:0] a;
        logic [1:0] cov, ebits;
        logic up, sof, last;
        for (int k = 0; k < L; k++) first[k] = 1'b1;
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                sof  = (x == 0 && y == 0);
                last = (x == w - 1);
                for (int k = 0; k < L; k++) begin
                    if (rnd_cover) cov[k] = 1'($urandom_range(0, 1));
                    else cov[k] = (x >= rx[k] && x < rx[k] + rw[k] && y >= ry[k] && y < ry[k] + rh[k]);
                end
                up    = 1'($urandom_range(0, 1));
                bg    = base_zero ? 24'h0 : 24'($urandom);
                ebits = (sof || y < mid_row) ? en_sof : en_mid;
                bq.push_back('{d: bg, u: {up, cov, sof}, l: last, en: ebits});
                px = bg;
                for (int k = 0; k < L; k++) begin
                    if (cov[k] && en_sof[k]) begin
                        v = (lval[k] < 0) ? 24'($urandom) : {3{8'(lval[k])}};
                        if (lalp[k] < 0) a = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
                        else a = 8'(lalp[k]);
                        lq[k].push_back('{d: {a, v}, sof: first[k]});
                        first[k] = 1'b0;
                        px = mix(px, v, a);
                    end
                end
                sb.push_back('{d: px, u: {up, sof}, l: last});
            end
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || bq.size() != 0 || lq[0].size() != 0 || lq[1].size() != 0) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", (n >= 5000), 0);
    endtask

    task automatic wait_out(input int target);
        int n = 0;
        while (out_cnt < target && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("wait_out_timeout", (n >= 5000), 0);
    endtask

    // Source driver: presents queued beats with optional gaps and holds them until accepted.
    initial begin : drive
        bit s0x;
        bit lx [L];
        logic [L-1:0] v, u;
        logic [L*LW-1:0] d;
        s0x = 1'b0;
        for (int k = 0; k < L; k++) begin lx[k] = 1'b0; hs_cnt[k] = 0; end
        forever begin
            @(negedge clk);
            if (halt) begin
                s0x = 1'b0;
                for (int k = 0; k < L; k++) lx[k] = 1'b0;
            end else begin
                if (s0x) void'(bq.pop_front());
                for (int k = 0; k < L; k++) if (lx[k]) void'(lq[k].pop_front());
                if (!(s0_axis_tvalid && !s0x))
                    s0_axis_tvalid = (bq.size() > 0) && (det || $urandom_range(0, 3) != 0);
                if (bq.size() > 0) begin
                    s0_axis_tdata = bq[0].d;
                    s0_axis_tuser = bq[0].u;
                    s0_axis_tlast = bq[0].l;
                    layer_enable  = bq[0].en;
                end
                v = sl_axis_tvalid; u = sl_axis_tuser; d = sl_axis_tdata;
                for (int k = 0; k < L; k++) begin
                    if (!(v[k] && !lx[k])) v[k] = (lq[k].size() > 0) && (det || $urandom_range(0, 2) != 0);
                    if (lq[k].size() > 0) begin
                        d[k*LW +: LW] = lq[k][0].d;
                        u[k] = lq[k][0].sof;
                    end
                end
                sl_axis_tvalid = v; sl_axis_tuser = u; sl_axis_tdata = d;
                #4;
                s0x = s0_axis_tvalid && s0_axis_tready;
                if (s0x && first_acc < 0) first_acc = cyc;
                for (int k = 0; k < L; k++) begin
                    lx[k] = sl_axis_tvalid[k] && sl_axis_tready[k];
                    if (lx[k]) hs_cnt[k]++;
                end
            end
        end
    end

    // Output monitor: randomises backpressure and checks each accepted beat against the scoreboard.
    initial begin : monitor
        exp_t e;
        m_axis_tready = 1'b0;
        forever begin
            @(negedge clk);
            m_axis_tready = halt ? 1'b0 : (det || $urandom_range(0, 3) != 0);
            #4;
            if (!halt && m_axis_tvalid && first_out < 0) first_out = cyc;
            if (!halt && m_axis_tvalid && m_axis_tready) begin
                out_cnt++;
                if (m_axis_tdata == watch) hits++;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_out data=%h user=%b last=%b", m_axis_tdata, m_axis_tuser, m_axis_tlast);
                end else begin
                    e = sb.pop_front();
                    if (m_axis_tdata !== e.d || m_axis_tuser !== e.u || m_axis_tlast !== e.l) begin
                        errors++;
                        $display("FAIL out%0d data=%h exp=%h user=%b exp=%b last=%b exp=%b",
                                 out_cnt, m_axis_tdata, e.d, m_axis_tuser, e.u, m_axis_tlast, e.l);
                    end
                end
            end
        end
    end

    initial begin : main
        int hb;
        reset = 1'b1;
        s0_axis_tvalid = 1'b1; s0_axis_tdata = 24'h123456; s0_axis_tuser = 4'b0001; s0_axis_tlast = 1'b0;
        sl_axis_tvalid = 2'b11; sl_axis_tdata = '0; sl_axis_tuser = 2'b00; layer_enable = 2'b11;
        en_sof = 2'b11; en_mid = 2'b11; mid_row = 0; rnd_cover = 1'b0; base_zero = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_m_tvalid", m_axis_tvalid, 0);
        chk("rst_m_tdata", m_axis_tdata, 0);
        chk("rst_m_tuser", m_axis_tuser, 0);
        chk("rst_m_tlast", m_axis_tlast, 0);
        chk("rst_sync_err", sync_err, 0);
        chk("rst_s0_tready", s0_axis_tready, 0);
        chk("rst_sl_tready", sl_axis_tready, 0);
        s0_axis_tvalid = 1'b0; sl_axis_tvalid = 2'b00;
        @(negedge clk);
        reset = 1'b0; halt = 1'b0;

        // opaque 3x4 layer at (3,2), back-to-back traffic for the latency check
        set_layer(0, 3, 2, 3, 4, 8'h55, 8'hFF); set_layer(1, 0, 0, 0, 0, 0, 0);
        watch = 24'h555555; hits = 0;
        build_frame(10, 8); drain();
        chk("latency", first_out - first_acc, 3);
        chk("opaque_hits", hits, 12);

        // half alpha over black, then fully transparent over random base
        det = 1'b0; base_zero = 1'b1;
        set_layer(0, 0, 0, 4, 2, 8'hFF, 8'h80);
        watch = 24'h7F7F7F; hits = 0;
        build_frame(4, 2); drain();
        chk("half_alpha_hits", hits, 8);
        base_zero = 1'b0;
        set_layer(0, 0, 0, 4, 2, 8'hFF, 8'h00);
        build_frame(4, 2); drain();

        // overlapping opaque layers: the higher index wins
        set_layer(0, 2, 1, 4, 3, 8'h11, 8'hFF); set_layer(1, 4, 2, 4, 3, 8'h22, 8'hFF);
        watch = 24'h222222; hits = 0;
        build_frame(10, 8); drain();
        chk("overlap_hits", hits, 12);

        // enable drop mid-frame, disabled frame stalls layer 0, following frame consumes it
        set_layer(0, 3, 2, 3, 4, -1, -1); set_layer(1, 0, 0, 0, 0, 0, 0);
        en_sof = 2'b11; en_mid = 2'b10; mid_row = 3;
        build_frame(10, 8); drain();
        hb = hs_cnt[0];
        en_sof = 2'b10; en_mid = 2'b10; mid_row = 0;
        build_frame(10, 8);
        en_sof = 2'b11; en_mid = 2'b11;
        build_frame(10, 8);
        wait_out(out_cnt + 80);
        chk("l0_stalled", hs_cnt[0], hb);
        drain();
        chk("l0_resumed", hs_cnt[0], hb + 12);

        // two stray non-SOF layer beats ahead of the frame are dropped and flagged
        chk("sync_err_pre", sync_err, 2'b00);
        lq[0].push_back('{d: 32'hFF00FF00, sof: 1'b0});
        lq[0].push_back('{d: 32'hFF0000FF, sof: 1'b0});
        build_frame(10, 8); drain();
        chk("sync_err_post", sync_err, 2'b01);

        // random coverage, colours, alpha, enables and backpressure
        rnd_cover = 1'b1; set_layer(0, 0, 0, 0, 0, -1, -1); set_layer(1, 0, 0, 0, 0, -1, -1);
        for (int f = 0; f < 3; f++) begin
            en_sof = 2'($urandom); en_mid = 2'($urandom); mid_row = $urandom_range(0, 5);
            build_frame($urandom_range(2, 12), $urandom_range(1, 6));
        end
        drain();

        // reset in the middle of a frame clears the output immediately
        en_sof = 2'b11; en_mid = 2'b11;
        build_frame(10, 8);
        wait_out(out_cnt + 20);
        @(negedge clk);
        halt = 1'b1;
        #1 reset = 1'b1;
        #1;
        chk("midrst_m_tvalid", m_axis_tvalid, 0);
        chk("midrst_m_tdata", m_axis_tdata, 0);
        chk("midrst_sync_err", sync_err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axis_blender_ml.md
Name: axis_blender_ml

Overview:
- Multi-layer successor to axis_blender: composites up to C_LAYER_NUM overlay AXI-stream layers onto a base video stream (s0), per pixel, with optional per-pixel alpha.
- Base tuser need-bits mark which layers cover each base pixel. Higher layer index is drawn on top.
- Sits in the video path between the frame readers and the display/encoder output.
- Adds a fixed-latency blend pipeline, per-layer enables latched at frame start, and layer SOF resynchronisation with sticky error flags.

Parameters:
- C_CHN_WIDTH, 8, bits per colour channel.
- C_S0_CHN_NUM, 3, base channels; equals output channel count.
- C_S1_CHN_NUM, 3, channels per layer; must be 1 or C_S0_CHN_NUM. 1 means grey, replicated to all output channels.
- C_ALPHA_WIDTH, 8, alpha bits at top of each layer beat; 0 means opaque replace.
- C_LAYER_NUM, 2, overlay layer count, 1..4.
- C_IN_NEED_WIDTH, 3, base tuser need-bit count; must be >= C_LAYER_NUM.
- C_OUT_NEED_WIDTH, 1, equals C_IN_NEED_WIDTH - C_LAYER_NUM.
- Derived: LW = C_S1_CHN_NUM*C_CHN_WIDTH + C_ALPHA_WIDTH; C_M_WIDTH = C_S0_CHN_NUM*C_CHN_WIDTH.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- s0_axis_tvalid/tready  in/out  1/1  base handshake.
- s0_axis_tdata  in  C_M_WIDTH  base pixel.
- s0_axis_tuser  in  C_IN_NEED_WIDTH+1  [0]=SOF; [k+1]=layer k covers this pixel; upper bits pass through.
- s0_axis_tlast  in  1  end of line.
- sl_axis_tvalid/tready  in/out  C_LAYER_NUM each  per-layer handshake.
- sl_axis_tdata  in  C_LAYER_NUM*LW  layer k occupies slice [k*LW +: LW]; alpha in the top C_ALPHA_WIDTH bits.
- sl_axis_tuser  in  C_LAYER_NUM  per-layer SOF.
- layer_enable  in  C_LAYER_NUM  requested layer enables.
- sync_err  out  C_LAYER_NUM  sticky: layer SOF misalignment seen.
- m_axis_tvalid/tready  out/in  1/1  output handshake.
- m_axis_tdata  out  C_M_WIDTH  blended pixel.
- m_axis_tuser  out  C_OUT_NEED_WIDTH+1  {s0 tuser[C_IN_NEED_WIDTH:C_LAYER_NUM+1], SOF}.
- m_axis_tlast  out  1  delayed s0 tlast.

Behaviour:
- Reset (async, active-high): all stage valids = 0; m_axis_tvalid = 0; m_axis_tdata/tuser/tlast = 0; sync_err = 0; en_lat = 0; expect_sof = all ones; all tready = 0.
- Pipeline: stage 0 (join) plus stages 1..C_LAYER_NUM, one per layer in index order. adv = ~m_axis_tvalid | m_axis_tready. All stages shift together when adv; nothing moves otherwise. Latency from join to m_axis_tvalid = C_LAYER_NUM+1 cycles with tready held high. Full throughput of 1 pixel/clk.
- Join: need_k = s0_tuser[k+1] & en_eff_k.
  - en_eff_k = layer_enable[k] on a SOF beat; otherwise en_lat[k].
  - en_lat is loaded from layer_enable on each accepted SOF beat; mid-frame layer_enable changes are ignored.
  - Fire = adv & s0_valid & AND over k of (~need_k | (sl_valid[k] & ~drop_k)).
  - s0_tready = fire.
  - sl_tready[k] = (fire & need_k) | drop_k.
  - Layers with need_k = 0 are not consumed.
- Resync, per layer:
  - An accepted base SOF beat sets expect_sof[k].
  - drop_k = expect_sof[k] & sl_valid[k] & ~sl_tuser[k]: the beat is discarded and sync_err[k] is set.
  - Consuming a layer beat with SOF clears expect_sof[k].
  - Simultaneous base SOF and layer-SOF consume on the same cycle: expect_sof[k] ends cleared.
- Blend at stage k+1, when the captured need_k is set:
  - out = (fg*a' + bg*(2^AW - a')) >> AW per channel, where a' = 2^AW if alpha is all ones, else alpha. Products are computed at full width, then truncated; no rounding.
  - With AW = 0: out = fg.
  - Grey layers are replicated across channels before blending.
  - When need_k is clear: pass-through.
- m_axis_tlast and tuser are delayed alongside the data; tlast is not checked against layer tlast.
- tdata and tuser are stable while m_axis_tvalid is high and tready is low.

Test Plan:
- 10x8 base, one 3x4 layer at (3,2), alpha=0xFF, layer value 0x55 -> 12 output pixels = 0x555555, others equal base; first output 3 clks after first accept (C_LAYER_NUM=2).
- Alpha=0x80, fg=0xFF, bg=0x00 -> out 0x7F per channel; alpha=0x00 -> bg unchanged.
- Two overlapping layers at the same pixel, opaque, values 0x11 (k=0) and 0x22 (k=1) -> 0x222222.
- layer_enable[0] dropped mid-frame -> layer still blended until next SOF; next frame layer 0 not consumed and its stream is stalled.
- Layer 0 issues 2 non-SOF beats before its SOF -> both dropped, sync_err[0]=1, correct image after.
- Random m_tready/s_valid for 3 frames -> output bit-exact vs model; no beat lost; data stable during stalls; reset asserted mid-frame -> m_axis_tvalid=0 immediately.
